i2c_eeprom_slave: RTL and testbench

Synthesizable I2C target that emulates a 24LC32A/24AA32A-style EEPROM. It is the responder to the APB EEPROM I2C master. It decodes control, address-high and address-low bytes, accepts page writes, and serves random, current-address and sequential reads from an internal byte array. It is used as the on-chip device model in system benches and as a register-backed EEPROM stand-in on FPGA.

---
 rtl/i2c_eeprom_slave.sv | 270 +++++++++++++++++++++++++++
 tb/tb_i2c_eeprom_slave.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_eeprom_slave.sv
// i2c_eeprom_slave: I2C target emulating a 24LC32A-style EEPROM.
// It decodes the control byte and two address bytes, accepts page writes,
// and serves random, current-address and sequential reads.
// Optional macro I2C_EEPROM_WR_CYCLE_EN: after a STOP that ends a write, a
// WR_CYCLE_CLKS busy window NACKs control bytes so the master can ACK-poll.
module i2c_eeprom_slave #(
  parameter logic [6:0] SLV_ADDR      = 7'h01,
  parameter int         AWIDTH        = 10,
  parameter int         PAGE_SIZE     = 32,
  parameter int         WR_CYCLE_CLKS = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i2c_SCL_i,
  input  logic              i2c_SDA_i,
  output logic              i2c_SDA_o,
  output logic              i2c_SDA_e,
  output logic              busy,
  output logic              wr_pulse,
  output logic [AWIDTH-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic [AWIDTH-1:0] dbg_raddr,
  output logic [7:0]        dbg_rdata
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH-1:0] PAGE_MASK = AWIDTH'(PAGE_SIZE - 1);

  // Reject parameter sets the address arithmetic cannot support.
  if (PAGE_SIZE < 1 || PAGE_SIZE > DEPTH || (PAGE_SIZE & (PAGE_SIZE - 1)) != 0 ||
      WR_CYCLE_CLKS < 1 || AWIDTH > 16) begin : g_param_check
    $error("i2c_eeprom_slave: illegal parameter combination");
  end

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, ACK_DEV, ADDR_HI, ACK_HI, ADDR_LO, ACK_LO,
    WR_DATA, ACK_WR, RD_DATA, RD_ACK
  } state_t;

  // bit 0 = SCL, bit 1 = SDA
  logic [1:0] pad_in, sync1_reg, sync2_reg, prev_reg;
  logic       scl_rise, scl_fall, start_det, stop_det;

  state_t            state_reg, state_next;
  logic [3:0]        bit_cnt_reg, bit_cnt_next;
  logic [7:0]        shift_reg, shift_next;
  logic              rw_reg, rw_next;
  logic [7:0]        addr_hi_reg, addr_hi_next;
  logic [AWIDTH-1:0] addr_ptr_reg, addr_ptr_next;
  logic              sda_e_reg, sda_e_next;
  logic              busy_reg, busy_next;
  logic              wr_pulse_reg, wr_pulse_next;
  logic [AWIDTH-1:0] wr_addr_reg, wr_addr_next;
  logic [7:0]        wr_data_reg, wr_data_next;

  logic [7:0]        sh_in;
  logic [AWIDTH-1:0] page_inc;
  logic              mem_we;
  logic              wr_hold;

  logic [7:0] mem [DEPTH];
  logic [7:0] rd_data_reg;

  assign pad_in = {i2c_SDA_i, i2c_SCL_i};

  // Two-flop synchronizers plus a previous-value flop for edge detection; idle bus is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 2'b11;
      sync2_reg <= 2'b11;
      prev_reg  <= 2'b11;
    end else begin
      sync1_reg <= pad_in;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign scl_rise  =  sync2_reg[0] & ~prev_reg[0];
  assign scl_fall  = ~sync2_reg[0] &  prev_reg[0];
  assign start_det =  sync2_reg[0] &  prev_reg[0] &  prev_reg[1] & ~sync2_reg[1];
  assign stop_det  =  sync2_reg[0] &  prev_reg[0] & ~prev_reg[1] &  sync2_reg[1];

  assign sh_in    = {shift_reg[6:0], sync2_reg[1]};
  // Page writes roll over inside the page; upper address bits stay put.
  assign page_inc = (addr_ptr_reg & ~PAGE_MASK) | ((addr_ptr_reg + AWIDTH'(1)) & PAGE_MASK);

`ifdef I2C_EEPROM_WR_CYCLE_EN
  localparam int CNT_W = $clog2(WR_CYCLE_CLKS + 1);
  logic [CNT_W-1:0] wr_cnt_reg;
  logic             wrote_reg;

  // Internal write-time counter, armed by a STOP that closes a transaction with committed bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_reg <= '0;
      wrote_reg  <= 1'b0;
    end else if (stop_det && (wrote_reg || mem_we)) begin
      wr_cnt_reg <= CNT_W'(WR_CYCLE_CLKS);
      wrote_reg  <= 1'b0;
    end else begin
      if (wr_cnt_reg != '0) wr_cnt_reg <= wr_cnt_reg - CNT_W'(1);
      if (mem_we) wrote_reg <= 1'b1;
    end
  end

  assign wr_hold = (wr_cnt_reg != '0);
`else
  assign wr_hold = 1'b0;
`endif

  // Protocol state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      rw_reg       <= 1'b0;
      addr_hi_reg  <= '0;
      addr_ptr_reg <= '0;
      sda_e_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      wr_pulse_reg <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      rw_reg       <= rw_next;
      addr_hi_reg  <= addr_hi_next;
      addr_ptr_reg <= addr_ptr_next;
      sda_e_reg    <= sda_e_next;
      busy_reg     <= busy_next;
      wr_pulse_reg <= wr_pulse_next;
      wr_addr_reg  <= wr_addr_next;
      wr_data_reg  <= wr_data_next;
    end
  end

  // Next-state logic; ACK states use sda_e_reg as their phase (first fall drives, second releases).
  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    rw_next       = rw_reg;
    addr_hi_next  = addr_hi_reg;
    addr_ptr_next = addr_ptr_reg;
    sda_e_next    = sda_e_reg;
    busy_next     = busy_reg;
    wr_pulse_next = 1'b0;
    wr_addr_next  = wr_addr_reg;
    wr_data_next  = wr_data_reg;
    mem_we        = 1'b0;

    if (stop_det) begin
      state_next   = IDLE;
      bit_cnt_next = '0;
      sda_e_next   = 1'b0;
      busy_next    = 1'b0;
    end else if (start_det) begin
      state_next   = DEV_ADDR;
      bit_cnt_next = '0;
      sda_e_next   = 1'b0;
    end else begin
      case (state_reg)
        IDLE: ;
        DEV_ADDR, ADDR_HI, ADDR_LO, WR_DATA: begin
          if (scl_rise) begin
            shift_next   = sh_in;
            bit_cnt_next = bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == 4'd7) begin
              bit_cnt_next = '0;
              case (state_reg)
                DEV_ADDR: begin
                  if (sh_in[7:1] == SLV_ADDR && !wr_hold) begin
                    state_next = ACK_DEV;
                    busy_next  = 1'b1;
                    rw_next    = sh_in[0];
                  end else begin
                    state_next = IDLE;
                  end
                end
                ADDR_HI: begin
                  addr_hi_next = sh_in;
                  state_next   = ACK_HI;
                end
                ADDR_LO: state_next = ACK_LO;
                default: begin
                  mem_we        = 1'b1;
                  wr_pulse_next = 1'b1;
                  wr_addr_next  = addr_ptr_reg;
                  wr_data_next  = sh_in;
                  addr_ptr_next = page_inc;
                  state_next    = ACK_WR;
                end
              endcase
            end
          end
        end
        ACK_DEV, ACK_HI, ACK_LO, ACK_WR: begin
          if (scl_fall) begin
            if (!sda_e_reg) begin
              sda_e_next = 1'b1;
            end else begin
              sda_e_next = 1'b0;
              case (state_reg)
                ACK_DEV: begin
                  if (rw_reg) begin
                    state_next   = RD_DATA;
                    shift_next   = rd_data_reg;
                    sda_e_next   = ~rd_data_reg[7];
                    bit_cnt_next = '0;
                  end else begin
                    state_next = ADDR_HI;
                  end
                end
                ACK_HI: state_next = ADDR_LO;
                ACK_LO: begin
                  addr_ptr_next = AWIDTH'({addr_hi_reg, shift_reg});
                  state_next    = WR_DATA;
                end
                default: state_next = WR_DATA;
              endcase
            end
          end
        end
        RD_DATA: begin
          if (scl_rise && bit_cnt_reg != 4'd8) begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_reg == 4'd8) begin
              sda_e_next    = 1'b0;
              state_next    = RD_ACK;
              bit_cnt_next  = '0;
              addr_ptr_next = addr_ptr_reg + AWIDTH'(1);
            end else if (bit_cnt_reg == 4'd0) begin
              shift_next = rd_data_reg;
              sda_e_next = ~rd_data_reg[7];
            end else begin
              sda_e_next = ~shift_reg[~bit_cnt_reg[2:0]];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            bit_cnt_next = '0;
            state_next   = sync2_reg[1] ? IDLE : RD_DATA;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Byte array: synchronous write, registered read feeding the read shifter.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_ptr_reg] <= sh_in;
    rd_data_reg <= mem[addr_ptr_reg];
  end

  assign dbg_rdata = mem[dbg_raddr];
  assign i2c_SDA_o = 1'b0;
  assign i2c_SDA_e = sda_e_reg;
  assign busy      = busy_reg | wr_hold;
  assign wr_pulse  = wr_pulse_reg;
  assign wr_addr   = wr_addr_reg;
  assign wr_data   = wr_data_reg;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// tb_i2c_eeprom_slave: directed bench acting as I2C master for i2c_eeprom_slave.
// Optional section exercises I2C_EEPROM_WR_CYCLE_EN when that macro is defined.
`timescale 1ns/1ps
module tb_i2c_eeprom_slave;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          scl, sda_m;
  logic          sda_line;
  logic          sda_o, sda_e, busy, wr_pulse;
  logic [AW-1:0] wr_addr, dbg_raddr;
  logic [7:0]    wr_data, dbg_rdata;

  int q = 100;
  int n_checks = 0, n_pass = 0, n_fail = 0;
  int wr_cnt = 0, sda_e_clks = 0;
  logic [AW-1:0] wr_a_log [64];
  logic [7:0]    wr_d_log [64];

  assign sda_line = sda_m & ~sda_e;

  i2c_eeprom_slave #(
    .SLV_ADDR(7'h01), .AWIDTH(AW), .PAGE_SIZE(32), .WR_CYCLE_CLKS(200)
  ) dut (
    .clk(clk), .rst(rst), .i2c_SCL_i(scl), .i2c_SDA_i(sda_line),
    .i2c_SDA_o(sda_o), .i2c_SDA_e(sda_e), .busy(busy), .wr_pulse(wr_pulse),
    .wr_addr(wr_addr), .wr_data(wr_data), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  // Log committed writes and count cycles with SDA driven.
  always @(negedge clk) begin
    if (wr_pulse) begin
      wr_a_log[wr_cnt % 64] <= wr_addr;
      wr_d_log[wr_cnt % 64] <= wr_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (sda_e) sda_e_clks <= sda_e_clks + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
      $display("check %-14s observed 0x%0h expected 0x%0h ok", tag, obs, exp);
    end else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_mem(input logic [AW-1:0] a, input logic [7:0] exp);
    dbg_raddr = a;
    #1;
    check($sformatf("mem[%03h]", a), 32'(dbg_rdata), 32'(exp));
  endtask

  task automatic bus_start();
    sda_m = 1'b1; #(q); scl = 1'b1; #(q); sda_m = 1'b0; #(q); scl = 1'b0; #(q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #(q); scl = 1'b1; #(q); sda_m = 1'b1; #(q);
  endtask

  task automatic put_bit(input logic b);
    sda_m = b; #(q); scl = 1'b1; #(2*q); scl = 1'b0; #(q);
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; #(q); scl = 1'b1; #(q); b = sda_line; #(q); scl = 1'b0; #(q);
  endtask

  task automatic put_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack);
  endtask

  task automatic get_byte(output logic [7:0] d, input logic master_ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(master_ack);
  endtask

  task automatic write_one(input logic [15:0] a, input logic [7:0] d);
    logic ack;
    bus_start();
    put_byte(8'h02, ack);
    put_byte(a[15:8], ack);
    put_byte(a[7:0], ack);
    put_byte(d, ack);
    bus_stop();
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd;
    int         w0, e0;
    logic [7:0] wbytes [4];
    logic [7:0] pbytes [3];
    logic [AW-1:0] paddr [3];
    wbytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    pbytes = '{8'h11, 8'h22, 8'h33};
    paddr  = '{10'h03E, 10'h03F, 10'h020};

    rst = 1'b1; scl = 1'b1; sda_m = 1'b1; dbg_raddr = '0;
    #100;
    check("rst_sda_e", 32'(sda_e), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_wr_pulse", 32'(wr_pulse), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    rst = 1'b0;
    #200;

    // Page write DE AD BE EF at 0x123
    w0 = wr_cnt;
    bus_start();
    put_byte(8'h02, ack); check("wr_ctrl_ack", 32'(ack), 0);
    check("wr_busy", 32'(busy), 1);
    put_byte(8'h01, ack); check("wr_hi_ack", 32'(ack), 0);
    put_byte(8'h23, ack); check("wr_lo_ack", 32'(ack), 0);
    for (int i = 0; i < 4; i++) begin
      put_byte(wbytes[i], ack);
      check($sformatf("wr_d%0d_ack", i), 32'(ack), 0);
    end
    bus_stop();
    #200;
    check("wr_pulses", 32'(wr_cnt - w0), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wr_addr%0d", i), 32'(wr_a_log[(w0 + i) % 64]), 32'h123 + 32'(i));
      check($sformatf("wr_data%0d", i), 32'(wr_d_log[(w0 + i) % 64]), 32'(wbytes[i]));
      chk_mem(10'h123 + 10'(i), wbytes[i]);
    end

    // Random read of 4 bytes from 0x123
    w0 = wr_cnt;
    bus_start();
    put_byte(8'h02, ack); check("rr_ctrl_ack", 32'(ack), 0);
    put_byte(8'h01, ack); check("rr_hi_ack", 32'(ack), 0);
    put_byte(8'h23, ack); check("rr_lo_ack", 32'(ack), 0);
    bus_start();
    put_byte(8'h03, ack); check("rr_rctrl_ack", 32'(ack), 0);
    for (int i = 0; i < 4; i++) begin
      get_byte(rd, (i == 3));
      check($sformatf("rr_byte%0d", i), 32'(rd), 32'(wbytes[i]));
    end
    check("rr_nack_sda_e", 32'(sda_e), 0);
    bus_stop();
    #200;
    check("rr_no_writes", 32'(wr_cnt - w0), 0);

    // Page wrap: 11 22 33 from 0x03E, with 0x040 and 0x050 preloaded
    write_one(16'h0040, 8'h5A);
    #200;
    write_one(16'h0050, 8'h77);
    #200;
    w0 = wr_cnt;
    bus_start();
    put_byte(8'h02, ack);
    put_byte(8'h00, ack);
    put_byte(8'h3E, ack);
    for (int i = 0; i < 3; i++) put_byte(pbytes[i], ack);
    bus_stop();
    #200;
    check("pw_pulses", 32'(wr_cnt - w0), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("pw_addr%0d", i), 32'(wr_a_log[(w0 + i) % 64]), 32'(paddr[i]));
      chk_mem(paddr[i], pbytes[i]);
    end
    chk_mem(10'h040, 8'h5A);

    // Address mismatch: control byte 0x0A
    w0 = wr_cnt;
    e0 = sda_e_clks;
    bus_start();
    put_byte(8'h0A, ack); check("mm_ctrl_nack", 32'(ack), 1);
    check("mm_busy", 32'(busy), 0);
    put_byte(8'h01, ack);
    put_byte(8'h23, ack);
    put_byte(8'h00, ack);
    bus_stop();
    #200;
    check("mm_sda_e_clks", 32'(sda_e_clks - e0), 0);
    check("mm_no_writes", 32'(wr_cnt - w0), 0);
    chk_mem(10'h123, 8'hDE);

    // Abort: STOP after 5 data bits at 0x050
    w0 = wr_cnt;
    bus_start();
    put_byte(8'h02, ack);
    put_byte(8'h00, ack);
    put_byte(8'h50, ack);
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0); put_bit(1'b1);
    bus_stop();
    #200;
    check("ab_no_writes", 32'(wr_cnt - w0), 0);
    check("ab_busy", 32'(busy), 0);
    chk_mem(10'h050, 8'h77);
    bus_start();
    put_byte(8'h03, ack); check("ca_ctrl_ack", 32'(ack), 0);
    get_byte(rd, 1'b1);
    check("ca_byte", 32'(rd), 32'h77);
    bus_stop();
    #200;

    // Reset in the middle of a read (0x77 bit 7 is 0, so SDA is driven)
    bus_start();
    put_byte(8'h02, ack);
    put_byte(8'h00, ack);
    put_byte(8'h50, ack);
    bus_start();
    put_byte(8'h03, ack);
    check("rr2_sda_driven", 32'(sda_e), 1);
    #3 rst = 1'b1;
    #1;
    check("rst_mid_sda_e", 32'(sda_e), 0);
    check("rst_mid_busy", 32'(busy), 0);
    #50 rst = 1'b0;
    bus_stop();
    #200;

`ifdef I2C_EEPROM_WR_CYCLE_EN
    // Internal write cycle: control byte NACKed right after a write, ACKed later
    q = 20;
    write_one(16'h0060, 8'h99);
    bus_start();
    put_byte(8'h02, ack); check("wc_poll_nack", 32'(ack), 1);
    check("wc_busy", 32'(busy), 1);
    bus_stop();
    repeat (200) @(posedge clk);
    #1;
    bus_start();
    put_byte(8'h02, ack); check("wc_poll_ack", 32'(ack), 0);
    bus_stop();
    #200;
    chk_mem(10'h060, 8'h99);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #20ms;
    $display("FAIL timeout: simulation did not reach its summary, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
